// File: rtl/spi_regfile_arbiter.sv
// Arbitrates a single-port register file between the SPI slave datapath (never stalls)
// and a local host req/gnt port; owns the SPI auto-increment pointer.
module spi_regfile_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              SCLK,
  input  logic              RST_n,
  input  logic              spi_addr_en,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_wr_en,
  input  logic [DATA_W-1:0] spi_wr_data,
  input  logic              spi_rd_en,
  input  logic              spi_incr,
  output logic [DATA_W-1:0] spi_rd_data,
  output logic              spi_rd_valid,
  output logic              spi_err,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [CNT_W-1:0]  host_stall_cnt,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              rf_re,
  input  logic [DATA_W-1:0] rf_rdata
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_SPI_WR, OWN_SPI_RD, OWN_HOST} owner_t;

  owner_t            owner;
  logic              spi_req;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              rf_tag_q;
  logic              rd_pend_q;
  logic              rd_tag_q;
  logic [DATA_W-1:0] spi_hold_q;
  logic [DATA_W-1:0] host_hold_q;

  assign spi_req  = spi_wr_en | spi_rd_en;
  assign acc_addr = spi_addr_en ? spi_addr : ptr_q;
  assign ptr_nxt  = spi_incr ? acc_addr + ADDR_W'(1) : acc_addr;

  always_comb begin
    owner = OWN_IDLE;
    if (spi_wr_en)      owner = OWN_SPI_WR;
    else if (spi_rd_en) owner = OWN_SPI_RD;
    else if (host_req)  owner = OWN_HOST;
  end

  always_ff @(posedge SCLK) begin
    if (!RST_n) begin
      ptr_q          <= '0;
      rf_addr        <= '0;
      rf_wdata       <= '0;
      rf_we          <= 1'b0;
      rf_re          <= 1'b0;
      rf_tag_q       <= 1'b0;
      host_gnt       <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_tag_q       <= 1'b0;
      spi_hold_q     <= '0;
      host_hold_q    <= '0;
      spi_err        <= 1'b0;
      host_stall_cnt <= '0;
    end else begin
      ptr_q    <= ptr_nxt;
      rf_we    <= 1'b0;
      rf_re    <= 1'b0;
      rf_tag_q <= 1'b0;
      host_gnt <= 1'b0;
      case (owner)
        OWN_SPI_WR: begin
          rf_we    <= 1'b1;
          rf_addr  <= acc_addr;
          rf_wdata <= spi_wr_data;
        end
        OWN_SPI_RD: begin
          rf_re   <= 1'b1;
          rf_addr <= acc_addr;
        end
        OWN_HOST: begin
          rf_we    <= host_we;
          rf_re    <= !host_we;
          rf_addr  <= host_addr;
          rf_wdata <= host_wdata;
          rf_tag_q <= 1'b1;
          host_gnt <= 1'b1;
        end
        default: ;
      endcase

      // Tag follows rf_re by one cycle so the returning word lands on the right port.
      rd_pend_q <= rf_re;
      rd_tag_q  <= rf_tag_q;
      if (rd_pend_q && !rd_tag_q) spi_hold_q  <= rf_rdata;
      if (rd_pend_q && rd_tag_q)  host_hold_q <= rf_rdata;

      if (spi_wr_en && spi_rd_en) spi_err <= 1'b1;
      if (host_req && spi_req && (host_stall_cnt != {CNT_W{1'b1}}))
        host_stall_cnt <= host_stall_cnt + CNT_W'(1);
    end
  end

  assign spi_rd_valid = rd_pend_q & ~rd_tag_q;
  assign host_rvalid  = rd_pend_q & rd_tag_q;
  assign spi_rd_data  = spi_rd_valid ? rf_rdata : spi_hold_q;
  assign host_rdata   = host_rvalid ? rf_rdata : host_hold_q;

endmodule

// File: tb/tb_spi_regfile_arbiter.sv
// Directed bench for spi_regfile_arbiter with a synchronous one-cycle-latency register file model.
module tb_spi_regfile_arbiter;
  logic       SCLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       spi_addr_en = 1'b0;
  logic [7:0] spi_addr = 8'h00;
  logic       spi_wr_en = 1'b0;
  logic [7:0] spi_wr_data = 8'h00;
  logic       spi_rd_en = 1'b0;
  logic       spi_incr = 1'b0;
  logic [7:0] spi_rd_data;
  logic       spi_rd_valid;
  logic       spi_err;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = 8'h00;
  logic [7:0] host_wdata = 8'h00;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [7:0] host_stall_cnt;
  logic [7:0] rf_addr;
  logic [7:0] rf_wdata;
  logic       rf_we;
  logic       rf_re;
  logic [7:0] rf_rdata = 8'h00;

  logic [7:0] mem [256];
  int total = 0;
  int bad = 0;

  spi_regfile_arbiter dut (
    .SCLK(SCLK), .RST_n(RST_n),
    .spi_addr_en(spi_addr_en), .spi_addr(spi_addr), .spi_wr_en(spi_wr_en),
    .spi_wr_data(spi_wr_data), .spi_rd_en(spi_rd_en), .spi_incr(spi_incr),
    .spi_rd_data(spi_rd_data), .spi_rd_valid(spi_rd_valid), .spi_err(spi_err),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_stall_cnt(host_stall_cnt),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_re(rf_re),
    .rf_rdata(rf_rdata)
  );

  always #5 SCLK = ~SCLK;

  always @(posedge SCLK) begin
    if (rf_we) mem[rf_addr] <= rf_wdata;
    if (rf_re) rf_rdata <= mem[rf_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge SCLK);
    @(negedge SCLK);
  endtask

  task automatic clr_in;
    spi_addr_en = 1'b0; spi_wr_en = 1'b0; spi_rd_en = 1'b0; spi_incr = 1'b0;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic test_reset;
    clr_in();
    RST_n = 1'b0;
    tick(); tick();
    total++; if ({rf_we, rf_re, host_gnt, host_rvalid, spi_rd_valid, spi_err} !== 6'b0) begin bad++;
      $display("FAIL reset_flags: got %b want 000000", {rf_we, rf_re, host_gnt, host_rvalid, spi_rd_valid, spi_err}); end
    total++; if ({rf_addr, rf_wdata, host_stall_cnt} !== 24'h0) begin bad++;
      $display("FAIL reset_regs: got %h want 000000", {rf_addr, rf_wdata, host_stall_cnt}); end
    total++; if ({spi_rd_data, host_rdata} !== 16'h0) begin bad++;
      $display("FAIL reset_rdata: got %h want 0000", {spi_rd_data, host_rdata}); end
    RST_n = 1'b1;
    tick();
  endtask

  task automatic test_spi_read_latency;
    spi_addr_en = 1'b1; spi_addr = 8'h10; spi_wr_en = 1'b1; spi_wr_data = 8'h5C;
    tick();
    total++; if ({rf_we, rf_re, rf_addr, rf_wdata} !== {2'b10, 8'h10, 8'h5C}) begin bad++;
      $display("FAIL lat_wr_issue: got we=%b re=%b addr=%h data=%h want we=1 re=0 addr=10 data=5c", rf_we, rf_re, rf_addr, rf_wdata); end
    clr_in();
    spi_addr_en = 1'b1; spi_addr = 8'h10; spi_rd_en = 1'b1;
    tick();
    clr_in();
    total++; if ({rf_re, rf_we, rf_addr, spi_rd_valid} !== {2'b10, 8'h10, 1'b0}) begin bad++;
      $display("FAIL lat_rd_issue: got re=%b we=%b addr=%h valid=%b want re=1 we=0 addr=10 valid=0", rf_re, rf_we, rf_addr, spi_rd_valid); end
    tick();
    total++; if (spi_rd_valid !== 1'b1 || spi_rd_data !== 8'h5C) begin bad++;
      $display("FAIL lat_rd_return: got valid=%b data=%h want valid=1 data=5c", spi_rd_valid, spi_rd_data); end
    tick();
    total++; if (spi_rd_valid !== 1'b0 || spi_rd_data !== 8'h5C) begin bad++;
      $display("FAIL lat_rd_hold: got valid=%b data=%h want valid=0 data=5c", spi_rd_valid, spi_rd_data); end
  endtask

  task automatic test_wrap;
    spi_addr_en = 1'b1; spi_addr = 8'hFE;
    tick();
    clr_in();
    total++; if ({rf_we, rf_re} !== 2'b00) begin bad++;
      $display("FAIL wrap_load_quiet: got we=%b re=%b want 0 0", rf_we, rf_re); end
    spi_wr_en = 1'b1; spi_incr = 1'b1; spi_wr_data = 8'hA1;
    tick();
    clr_in();
    total++; if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 8'hFE, 8'hA1}) begin bad++;
      $display("FAIL wrap_wr1: got we=%b addr=%h data=%h want we=1 addr=fe data=a1", rf_we, rf_addr, rf_wdata); end
    repeat (7) tick();
    spi_wr_en = 1'b1; spi_incr = 1'b1; spi_wr_data = 8'hB2;
    tick();
    clr_in();
    total++; if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 8'hFF, 8'hB2}) begin bad++;
      $display("FAIL wrap_wr2: got we=%b addr=%h data=%h want we=1 addr=ff data=b2", rf_we, rf_addr, rf_wdata); end
    tick();
    spi_rd_en = 1'b1;
    tick();
    clr_in();
    total++; if (rf_re !== 1'b1 || rf_addr !== 8'h00) begin bad++;
      $display("FAIL wrap_ptr_zero: got re=%b addr=%h want re=1 addr=00", rf_re, rf_addr); end
    tick(); tick();
  endtask

  task automatic test_collision;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h77;
    spi_addr_en = 1'b1; spi_addr = 8'h10; spi_rd_en = 1'b1;
    tick();
    spi_addr_en = 1'b0; spi_rd_en = 1'b0;
    total++; if ({rf_re, rf_we, rf_addr, host_gnt} !== {2'b10, 8'h10, 1'b0}) begin bad++;
      $display("FAIL coll_spi_first: got re=%b we=%b addr=%h gnt=%b want re=1 we=0 addr=10 gnt=0", rf_re, rf_we, rf_addr, host_gnt); end
    tick();
    host_req = 1'b0;
    total++; if ({host_gnt, rf_we, rf_re, rf_addr, rf_wdata} !== {3'b110, 8'h10, 8'h77}) begin bad++;
      $display("FAIL coll_host_wr: got gnt=%b we=%b re=%b addr=%h data=%h want gnt=1 we=1 re=0 addr=10 data=77", host_gnt, rf_we, rf_re, rf_addr, rf_wdata); end
    total++; if (spi_rd_valid !== 1'b1 || spi_rd_data !== 8'h5C) begin bad++;
      $display("FAIL coll_old_data: got valid=%b data=%h want valid=1 data=5c", spi_rd_valid, spi_rd_data); end
    total++; if (host_stall_cnt !== 8'd1) begin bad++;
      $display("FAIL coll_stall: got %0d want 1", host_stall_cnt); end
    tick();
    total++; if (host_gnt !== 1'b0 || rf_we !== 1'b0) begin bad++;
      $display("FAIL coll_single_gnt: got gnt=%b we=%b want 0 0", host_gnt, rf_we); end
    spi_addr_en = 1'b1; spi_addr = 8'h10; spi_rd_en = 1'b1;
    tick();
    clr_in();
    tick();
    total++; if (spi_rd_valid !== 1'b1 || spi_rd_data !== 8'h77) begin bad++;
      $display("FAIL coll_new_data: got valid=%b data=%h want valid=1 data=77", spi_rd_valid, spi_rd_data); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'(i + 1); host_wdata = exp_d[i];
      tick();
      total++; if ({host_gnt, rf_we, rf_addr, rf_wdata} !== {2'b11, 8'(i + 1), exp_d[i]}) begin bad++;
        $display("FAIL b2b_wr%0d: got gnt=%b we=%b addr=%h data=%h want gnt=1 we=1 addr=%h data=%h", i, host_gnt, rf_we, rf_addr, rf_wdata, 8'(i + 1), exp_d[i]); end
    end
    host_we = 1'b0; host_addr = 8'h01;
    tick();
    total++; if ({host_gnt, rf_re, rf_addr, host_rvalid} !== {2'b11, 8'h01, 1'b0}) begin bad++;
      $display("FAIL b2b_rd0_issue: got gnt=%b re=%b addr=%h rvalid=%b want gnt=1 re=1 addr=01 rvalid=0", host_gnt, rf_re, rf_addr, host_rvalid); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) host_addr = 8'(i + 2);
      else host_req = 1'b0;
      tick();
      total++; if (host_gnt !== (i < 2) || host_rvalid !== 1'b1 || host_rdata !== exp_d[i]) begin bad++;
        $display("FAIL b2b_rd%0d: got gnt=%b rvalid=%b rdata=%h want gnt=%b rvalid=1 rdata=%h", i, host_gnt, host_rvalid, host_rdata, (i < 2), exp_d[i]); end
    end
    clr_in();
    tick();
    total++; if (host_rvalid !== 1'b0 || host_rdata !== 8'h33) begin bad++;
      $display("FAIL b2b_hold: got rvalid=%b rdata=%h want rvalid=0 rdata=33", host_rvalid, host_rdata); end
  endtask

  task automatic test_stall_saturate;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h01;
    spi_rd_en = 1'b1;
    repeat (300) tick();
    total++; if (host_stall_cnt !== 8'hFF) begin bad++;
      $display("FAIL stall_sat: got %0d want 255", host_stall_cnt); end
    total++; if (host_gnt !== 1'b0) begin bad++;
      $display("FAIL stall_no_gnt: got %b want 0", host_gnt); end
    spi_rd_en = 1'b0;
    tick();
    host_req = 1'b0;
    total++; if (host_gnt !== 1'b1 || host_stall_cnt !== 8'hFF) begin bad++;
      $display("FAIL stall_release: got gnt=%b cnt=%0d want gnt=1 cnt=255", host_gnt, host_stall_cnt); end
    tick(); tick();
  endtask

  task automatic test_illegal;
    spi_addr_en = 1'b1; spi_addr = 8'h20; spi_wr_en = 1'b1; spi_rd_en = 1'b1; spi_wr_data = 8'h99;
    tick();
    clr_in();
    total++; if ({rf_we, rf_re, rf_addr, rf_wdata} !== {2'b10, 8'h20, 8'h99}) begin bad++;
      $display("FAIL ill_issue: got we=%b re=%b addr=%h data=%h want we=1 re=0 addr=20 data=99", rf_we, rf_re, rf_addr, rf_wdata); end
    tick();
    total++; if (spi_rd_valid !== 1'b0 || spi_err !== 1'b1) begin bad++;
      $display("FAIL ill_err: got valid=%b err=%b want valid=0 err=1", spi_rd_valid, spi_err); end
    repeat (3) tick();
    total++; if (spi_err !== 1'b1) begin bad++;
      $display("FAIL ill_sticky: got %b want 1", spi_err); end
  endtask

  task automatic test_reset_mid_read;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h02;
    tick();
    clr_in();
    total++; if (rf_re !== 1'b1 || host_gnt !== 1'b1) begin bad++;
      $display("FAIL rst_mid_issue: got re=%b gnt=%b want 1 1", rf_re, host_gnt); end
    RST_n = 1'b0;
    tick();
    total++; if (host_rvalid !== 1'b0 || spi_rd_valid !== 1'b0) begin bad++;
      $display("FAIL rst_mid_no_rvalid: got host=%b spi=%b want 0 0", host_rvalid, spi_rd_valid); end
    total++; if ({rf_we, rf_re, host_gnt, spi_err, host_stall_cnt, rf_addr, rf_wdata, spi_rd_data, host_rdata} !== 44'h0) begin bad++;
      $display("FAIL rst_mid_zero: got we=%b re=%b gnt=%b err=%b cnt=%h addr=%h wd=%h srd=%h hrd=%h want all 0",
               rf_we, rf_re, host_gnt, spi_err, host_stall_cnt, rf_addr, rf_wdata, spi_rd_data, host_rdata); end
    RST_n = 1'b1;
    tick();
    total++; if (host_rvalid !== 1'b0 || spi_err !== 1'b0) begin bad++;
      $display("FAIL rst_mid_after: got rvalid=%b err=%b want 0 0", host_rvalid, spi_err); end
  endtask

  initial begin
    @(negedge SCLK);
    test_reset();
    test_spi_read_latency();
    test_wrap();
    test_collision();
    test_back_to_back();
    test_stall_saturate();
    test_illegal();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
